taxi_meter_core: RTL and testbench

- Parametrised next-generation fare engine. Replaces the fixed 4-digit fare / 2-digit distance datapath with configurable BCD widths, day/night tariffs, an included start distance, automatic wait detection, saturation and a trip state machine.
- Sits between the odometer pulse input / driver buttons and the seven-segment display layer.
- Outputs packed BCD fare and distance plus trip status.

---
 rtl/taxi_meter_pkg.sv | 30 +++
 rtl/bcd_add_n.sv | 32 +++
 rtl/taxi_meter_core.sv | 239 +++++++++++++++++++++++
 tb/tb_taxi_meter_core.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/taxi_meter_pkg.sv
// Shared definitions for the taxi fare engine.
//   - trip state encodings as driven on the state output
//   - BCD digit width
//   - all_nines(): saturation value for an n-digit packed BCD field
package taxi_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_HIRED   = 2'b01,
    ST_WAITING = 2'b10,
    ST_STOPPED = 2'b11
  } state_t;

  localparam int BCD_DIGIT = 4;

  // Packed BCD value with the lowest 'digits' digits set to 9 (up to 16 digits).
  function automatic logic [63:0] all_nines(input int digits);
    logic [63:0] r;
    r = 64'd0;
    for (int i = 0; i < 16; i++) begin
      if (i < digits) begin
        r[i*4 +: 4] = 4'h9;
      end else begin
        r[i*4 +: 4] = 4'h0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_add_n.sv
// Combinational multi-digit packed BCD adder.
//   a, b  : DIGITS-digit packed BCD operands
//   sum   : DIGITS-digit packed BCD result (modulo 10^DIGITS)
//   carry : carry out of the most significant digit
module bcd_add_n
  import taxi_meter_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic [BCD_DIGIT*DIGITS-1:0] a,
  input  logic [BCD_DIGIT*DIGITS-1:0] b,
  output logic [BCD_DIGIT*DIGITS-1:0] sum,
  output logic                        carry
);

  logic [DIGITS:0] c_s;

  assign c_s[0] = 1'b0;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [4:0] raw_s;
    assign raw_s = {1'b0, a[BCD_DIGIT*i +: BCD_DIGIT]}
                 + {1'b0, b[BCD_DIGIT*i +: BCD_DIGIT]}
                 + {4'd0, c_s[i]};
    // A binary digit sum above 9 is corrected by +6, which also drops the carry bit.
    assign c_s[i+1] = (raw_s > 5'd9);
    assign sum[BCD_DIGIT*i +: BCD_DIGIT] = c_s[i+1] ? 4'(raw_s + 5'd6) : raw_s[3:0];
  end

  assign carry = c_s[DIGITS];

endmodule

// File: rtl/taxi_meter_core.sv
// Taxi fare engine: trip state machine, distance and wait accounting,
// shared BCD fare adder with saturation.
//   clk, rst                       : clock, asynchronous active-high reset
//   start, stop, clear             : driver buttons (levels, rising-edge detected)
//   night_mode                     : tariff select, sampled on the start edge
//   pulse_10m                      : asynchronous odometer pulse, one per 10 m
//   day/night_start_fare, *_rate   : BCD tariffs, wait_rate per WAIT_UNIT_SEC
//   fare_bcd, dist_bcd             : packed BCD fare (0.1 yuan) and distance (0.1 km)
//   state                          : 00 IDLE, 01 HIRED, 10 WAITING, 11 STOPPED
//   overflow                       : sticky saturation flag
module taxi_meter_core
  import taxi_meter_pkg::*;
#(
  parameter int FARE_DIGITS   = 4,
  parameter int DIST_DIGITS   = 3,
  parameter int CLK_PER_SEC   = 50_000_000,
  parameter int BASE_DIST     = 30,
  parameter int STALL_SEC     = 10,
  parameter int WAIT_UNIT_SEC = 300
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             stop,
  input  logic                             clear,
  input  logic                             night_mode,
  input  logic                             pulse_10m,
  input  logic [BCD_DIGIT*FARE_DIGITS-1:0] day_start_fare,
  input  logic [BCD_DIGIT*FARE_DIGITS-1:0] night_start_fare,
  input  logic [BCD_DIGIT*FARE_DIGITS-1:0] day_rate,
  input  logic [BCD_DIGIT*FARE_DIGITS-1:0] night_rate,
  input  logic [BCD_DIGIT*FARE_DIGITS-1:0] wait_rate,
  output logic [BCD_DIGIT*FARE_DIGITS-1:0] fare_bcd,
  output logic [BCD_DIGIT*DIST_DIGITS-1:0] dist_bcd,
  output logic [1:0]                       state,
  output logic                             overflow
);

  localparam int FW      = BCD_DIGIT * FARE_DIGITS;
  localparam int DW      = BCD_DIGIT * DIST_DIGITS;
  localparam int SEC_W   = $clog2(CLK_PER_SEC + 1);
  localparam int STALL_W = $clog2(STALL_SEC + 1);
  localparam int WAIT_W  = $clog2(WAIT_UNIT_SEC + 1);
  localparam int BASE_W  = $clog2(BASE_DIST + 2);
  localparam logic [FW-1:0] FARE_MAX = FW'(all_nines(FARE_DIGITS));
  localparam logic [DW-1:0] DIST_ONE = DW'(1);

  state_t state_r, state_nx;

  logic pulse_s1_r, pulse_s2_r, pulse_s3_r;
  logic start_d_r, stop_d_r, clear_d_r;
  logic start_ev_s, stop_ev_s, clear_ev_s, pulse_ev_s;
  logic running_s, sec_tick_s, moving_s, dist_step_s, charge_s;
  logic stall_done_s, wait_wrap_s, wait_inc_s, add_en_s;

  logic [SEC_W-1:0]   sec_cnt_r;
  logic [3:0]         sub_cnt_r;
  logic [STALL_W-1:0] stall_cnt_r;
  logic [WAIT_W-1:0]  wait_sec_r;
  // Saturates at BASE_DIST: once there, every further 0.1 km is charged.
  logic [BASE_W-1:0]  base_cnt_r;

  logic [FW-1:0] fare_r, rate_r, wait_rate_r, addend_s, fare_sum_s;
  logic          fare_carry_s;
  logic [DW-1:0] dist_r, dist_sum_s;
  logic          dist_carry_s;
  logic          dist_pend_r, wait_pend_r, overflow_r;

  assign start_ev_s = start & ~start_d_r;
  assign stop_ev_s  = stop  & ~stop_d_r;
  assign clear_ev_s = clear & ~clear_d_r;
  assign pulse_ev_s = pulse_s2_r & ~pulse_s3_r;

  assign running_s    = (state_r == ST_HIRED) || (state_r == ST_WAITING);
  assign sec_tick_s   = running_s && (sec_cnt_r == SEC_W'(CLK_PER_SEC - 1));
  // A stop edge swallows a same-cycle pulse so no new fare request is created.
  assign moving_s     = running_s && pulse_ev_s && !stop_ev_s;
  assign dist_step_s  = moving_s && (sub_cnt_r == 4'd9);
  assign charge_s     = dist_step_s && !dist_carry_s && (base_cnt_r == BASE_W'(BASE_DIST));
  assign stall_done_s = (state_r == ST_HIRED) && sec_tick_s && !pulse_ev_s
                        && (stall_cnt_r == STALL_W'(STALL_SEC - 1));
  assign wait_wrap_s  = (state_r == ST_WAITING) && sec_tick_s
                        && (wait_sec_r == WAIT_W'(WAIT_UNIT_SEC - 1));
  assign wait_inc_s   = wait_wrap_s && !stop_ev_s;

  // Distance requests win the shared adder; a waiting request stays pending.
  assign add_en_s = dist_pend_r || wait_pend_r;
  assign addend_s = dist_pend_r ? rate_r : wait_rate_r;

  bcd_add_n #(.DIGITS(FARE_DIGITS)) u_fare_add (
    .a     (fare_r),
    .b     (addend_s),
    .sum   (fare_sum_s),
    .carry (fare_carry_s)
  );

  bcd_add_n #(.DIGITS(DIST_DIGITS)) u_dist_inc (
    .a     (dist_r),
    .b     (DIST_ONE),
    .sum   (dist_sum_s),
    .carry (dist_carry_s)
  );

  // Input conditioning: pulse synchroniser and button edge-detect history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_s1_r <= 1'b0;
      pulse_s2_r <= 1'b0;
      pulse_s3_r <= 1'b0;
      start_d_r  <= 1'b0;
      stop_d_r   <= 1'b0;
      clear_d_r  <= 1'b0;
    end else begin
      pulse_s1_r <= pulse_10m;
      pulse_s2_r <= pulse_s1_r;
      pulse_s3_r <= pulse_s2_r;
      start_d_r  <= start;
      stop_d_r   <= stop;
      clear_d_r  <= clear;
    end
  end

  // Trip state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Trip next-state logic.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ev_s) state_nx = ST_HIRED;
        else            state_nx = ST_IDLE;
      end
      ST_HIRED: begin
        if (stop_ev_s)         state_nx = ST_STOPPED;
        else if (stall_done_s) state_nx = ST_WAITING;
        else                   state_nx = ST_HIRED;
      end
      ST_WAITING: begin
        if (stop_ev_s)       state_nx = ST_STOPPED;
        else if (pulse_ev_s) state_nx = ST_HIRED;
        else                 state_nx = ST_WAITING;
      end
      ST_STOPPED: begin
        if (clear_ev_s) state_nx = ST_IDLE;
        else            state_nx = ST_STOPPED;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Fare/distance datapath, timers, pending adder requests and saturation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_cnt_r   <= SEC_W'(0);
      sub_cnt_r   <= 4'd0;
      stall_cnt_r <= STALL_W'(0);
      wait_sec_r  <= WAIT_W'(0);
      base_cnt_r  <= BASE_W'(0);
      fare_r      <= FW'(0);
      rate_r      <= FW'(0);
      wait_rate_r <= FW'(0);
      dist_r      <= DW'(0);
      dist_pend_r <= 1'b0;
      wait_pend_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else if (state_r == ST_IDLE) begin
      sec_cnt_r   <= SEC_W'(0);
      sub_cnt_r   <= 4'd0;
      stall_cnt_r <= STALL_W'(0);
      wait_sec_r  <= WAIT_W'(0);
      base_cnt_r  <= BASE_W'(0);
      dist_r      <= DW'(0);
      dist_pend_r <= 1'b0;
      wait_pend_r <= 1'b0;
      overflow_r  <= 1'b0;
      if (start_ev_s) begin
        fare_r      <= night_mode ? night_start_fare : day_start_fare;
        rate_r      <= night_mode ? night_rate : day_rate;
        wait_rate_r <= wait_rate;
      end else begin
        fare_r <= FW'(0);
      end
    end else if ((state_r == ST_STOPPED) && clear_ev_s) begin
      fare_r      <= FW'(0);
      dist_r      <= DW'(0);
      dist_pend_r <= 1'b0;
      wait_pend_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      sec_cnt_r <= (!running_s || sec_tick_s) ? SEC_W'(0) : sec_cnt_r + SEC_W'(1);

      if (moving_s) begin
        sub_cnt_r <= (sub_cnt_r == 4'd9) ? 4'd0 : sub_cnt_r + 4'd1;
      end
      if (dist_step_s && !dist_carry_s) begin
        dist_r <= dist_sum_s;
        if (base_cnt_r != BASE_W'(BASE_DIST)) begin
          base_cnt_r <= base_cnt_r + BASE_W'(1);
        end
      end

      if ((state_r == ST_HIRED) && !pulse_ev_s) begin
        if (sec_tick_s) begin
          stall_cnt_r <= stall_done_s ? STALL_W'(0) : stall_cnt_r + STALL_W'(1);
        end
      end else begin
        stall_cnt_r <= STALL_W'(0);
      end

      // Waiting time is never cleared mid-trip so it accumulates across stalls.
      if (wait_wrap_s) begin
        wait_sec_r <= WAIT_W'(0);
      end else if ((state_r == ST_WAITING) && sec_tick_s) begin
        wait_sec_r <= wait_sec_r + WAIT_W'(1);
      end

      dist_pend_r <= charge_s;
      wait_pend_r <= wait_inc_s || (wait_pend_r && dist_pend_r);

      if (add_en_s) begin
        fare_r <= fare_carry_s ? FARE_MAX : fare_sum_s;
      end
      overflow_r <= overflow_r || (add_en_s && fare_carry_s) || (dist_step_s && dist_carry_s);
    end
  end

  assign fare_bcd = fare_r;
  assign dist_bcd = dist_r;
  assign state    = state_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_taxi_meter_core.sv
// Directed bench for taxi_meter_core with short timing parameters
// (4 clk per second, 2 s stall, 3 s wait unit, 0.2 km included distance).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_taxi_meter_core;

  logic        clk;
  logic        rst;
  logic        start, stop, clear, night_mode, pulse_10m;
  logic [15:0] day_start_fare, night_start_fare, day_rate, night_rate, wait_rate;
  logic [15:0] fare_bcd;
  logic [11:0] dist_bcd;
  logic [1:0]  state;
  logic        overflow;

  int n_total;
  int n_pass;

  taxi_meter_core #(
    .FARE_DIGITS   (4),
    .DIST_DIGITS   (3),
    .CLK_PER_SEC   (4),
    .BASE_DIST     (2),
    .STALL_SEC     (2),
    .WAIT_UNIT_SEC (3)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .stop             (stop),
    .clear            (clear),
    .night_mode       (night_mode),
    .pulse_10m        (pulse_10m),
    .day_start_fare   (day_start_fare),
    .night_start_fare (night_start_fare),
    .day_rate         (day_rate),
    .night_rate       (night_rate),
    .wait_rate        (wait_rate),
    .fare_bcd         (fare_bcd),
    .dist_bcd         (dist_bcd),
    .state            (state),
    .overflow         (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // All stimulus tasks are entered on a falling edge and return on one.
  task automatic press_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic press_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic press_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // One odometer pulse: 2 clk high, 2 clk low; its event lands 3 clk after the rise.
  task automatic pulse_once();
    pulse_10m = 1'b1;
    repeat (2) @(negedge clk);
    pulse_10m = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_pulses(input int n);
    for (int i = 0; i < n; i++) pulse_once();
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_state"}, 32'(state), 32'd0);
    check_eq({tag, "_fare"}, 32'(fare_bcd), 32'd0);
    check_eq({tag, "_dist"}, 32'(dist_bcd), 32'd0);
    check_eq({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst = 1'b1;
    start = 1'b0; stop = 1'b0; clear = 1'b0; night_mode = 1'b0; pulse_10m = 1'b0;
    day_start_fare   = 16'h0080;
    day_rate         = 16'h0005;
    night_start_fare = 16'h0150;
    night_rate       = 16'h0007;
    wait_rate        = 16'h0012;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);

    // Day trip: only the third 0.1 km is charged; stop freezes; clear zeroes.
    press_start();
    check_eq("t1_state", 32'(state), 32'd1);
    check_eq("t1_fare0", 32'(fare_bcd), 32'h0080);
    check_eq("t1_dist0", 32'(dist_bcd), 32'h000);
    run_pulses(20);
    check_eq("t1_dist_base", 32'(dist_bcd), 32'h002);
    check_eq("t1_fare_base", 32'(fare_bcd), 32'h0080);
    run_pulses(10);
    check_eq("t1_dist", 32'(dist_bcd), 32'h003);
    check_eq("t1_fare", 32'(fare_bcd), 32'h0085);
    check_eq("t1_hired", 32'(state), 32'd1);
    press_stop();
    check_eq("t1_stopped", 32'(state), 32'd3);
    run_pulses(10);
    check_eq("t1_frz_dist", 32'(dist_bcd), 32'h003);
    check_eq("t1_frz_fare", 32'(fare_bcd), 32'h0085);
    press_start();
    check_eq("t1_start_ign", 32'(state), 32'd3);
    press_clear();
    check_idle("t1_clear");

    // Waiting: WAITING after 2 s, then +wait_rate every 3 s.
    press_start();
    repeat (7) @(negedge clk);
    check_eq("t2_hired_7s", 32'(state), 32'd1);
    @(negedge clk);
    check_eq("t2_waiting", 32'(state), 32'd2);
    repeat (12) @(negedge clk);
    check_eq("t2_fare_pre", 32'(fare_bcd), 32'h0080);
    @(negedge clk);
    check_eq("t2_fare_w1", 32'(fare_bcd), 32'h0092);
    repeat (12) @(negedge clk);
    check_eq("t2_fare_w2", 32'(fare_bcd), 32'h0104);
    press_stop();
    press_clear();

    // Pulse event colliding with wait_inc: dist add first, wait add next cycle.
    press_start();
    run_pulses(29);
    check_eq("t3_dist2", 32'(dist_bcd), 32'h002);
    repeat (4) @(negedge clk);
    check_eq("t3_waiting", 32'(state), 32'd2);
    repeat (9) @(negedge clk);
    pulse_once();
    check_eq("t3_dist3", 32'(dist_bcd), 32'h003);
    check_eq("t3_fare_dist", 32'(fare_bcd), 32'h0085);
    check_eq("t3_back_hired", 32'(state), 32'd1);
    @(negedge clk);
    check_eq("t3_fare_both", 32'(fare_bcd), 32'h0097);
    press_stop();
    press_clear();

    // Night tariff latched at start; mid-trip port changes ignored.
    night_mode = 1'b1;
    press_start();
    night_mode = 1'b0;
    night_rate = 16'h0009;
    night_start_fare = 16'h0200;
    day_rate = 16'h0003;
    check_eq("t4_fare0", 32'(fare_bcd), 32'h0150);
    run_pulses(30);
    check_eq("t4_fare", 32'(fare_bcd), 32'h0157);
    check_eq("t4_dist", 32'(dist_bcd), 32'h003);
    press_stop();
    press_clear();

    // Fare saturation and its clearing.
    day_start_fare = 16'h9990;
    day_rate = 16'h0020;
    press_start();
    check_eq("t5_fare0", 32'(fare_bcd), 32'h9990);
    run_pulses(20);
    check_eq("t5_ovf_pre", 32'(overflow), 32'd0);
    check_eq("t5_fare_pre", 32'(fare_bcd), 32'h9990);
    run_pulses(10);
    check_eq("t5_fare_sat", 32'(fare_bcd), 32'h9999);
    check_eq("t5_ovf", 32'(overflow), 32'd1);
    press_stop();
    check_eq("t5_stopped", 32'(state), 32'd3);
    check_eq("t5_ovf_stop", 32'(overflow), 32'd1);
    press_clear();
    check_idle("t5_clear");

    // Asynchronous reset while WAITING, then a clean restart.
    day_start_fare = 16'h0080;
    day_rate = 16'h0005;
    press_start();
    repeat (8) @(negedge clk);
    check_eq("t6_waiting", 32'(state), 32'd2);
    repeat (8) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_idle("t6_async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    press_start();
    check_eq("t6_restart", 32'(fare_bcd), 32'h0080);
    repeat (20) @(negedge clk);
    check_eq("t6_fare_pre", 32'(fare_bcd), 32'h0080);
    @(negedge clk);
    check_eq("t6_fare_w1", 32'(fare_bcd), 32'h0092);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
